// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and defaults for the instruction-fetch queue
package if_pkg;

  localparam int IF_XLEN = 32;
  localparam int IF_PC_INC = 4;
  localparam logic [IF_XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] pc4;
    logic [IF_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_BRANCH,
    SEL_JAL,
    SEL_JALR
  } redir_sel_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - DEPTH-entry queue of fetched instructions with synchronous clear
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; entries are only observed while counted.
  always_ff @(posedge CLOCK) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  overflow_check: assert property (@(posedge CLOCK) disable iff (!RESET)
    !(push && full && !pop));

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - decoupled IF stage: PC, redirect, imem issue and fetch queue (IF_BYPASS_EN)
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int               XLEN     = IF_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = IF_RESET_PC,
  parameter int               DEPTH    = 4,
  parameter int               PC_INC   = IF_PC_INC
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            IF_inREADY,
  input  logic            IF_inPCSRC,
  input  logic [XLEN-1:0] IF_inBRANCHGO,
  input  logic            IF_inJUMP,
  input  logic [XLEN-1:0] IF_inJJAL,
  input  logic            IF_inRJUMP,
  input  logic [XLEN-1:0] IF_inJRJALR,
  input  logic [XLEN-1:0] IF_inIDATA,
  output logic            IF_outIREQ,
  output logic [XLEN-1:0] IF_outIADADD,
  output logic            IF_outVALID,
  output logic [XLEN-1:0] IF_outINSTR,
  output logic [XLEN-1:0] IF_outPC,
  output logic [XLEN-1:0] IF_outgoifidpc4,
  output logic            IF_outFLASHIF
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            inflight_epoch;
  logic            epoch;

  redir_sel_t      sel;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            issue;
  logic            resp_ok;
  logic [CW:0]     occupancy;

  fetch_entry_t    resp_entry;
  fetch_entry_t    fifo_head;
  fetch_entry_t    head_sel;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            head_valid;

  always_comb begin
    sel    = SEL_NONE;
    target = pc_q;
    if (IF_inRJUMP) begin
      sel    = SEL_JALR;
      target = IF_inJRJALR;
    end else if (IF_inJUMP) begin
      sel    = SEL_JAL;
      target = IF_inJJAL;
    end else if (IF_inPCSRC) begin
      sel    = SEL_BRANCH;
      target = IF_inBRANCHGO;
    end
  end

  assign redirect  = (sel != SEL_NONE);
  // Conservative credit: a pop in this cycle does not free a slot for issue.
  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(inflight);
  assign issue     = RESET && !redirect && !fifo_full && (occupancy < (CW + 1)'(DEPTH));
  assign resp_ok   = inflight && (inflight_epoch == epoch) && !redirect;

  assign resp_entry.pc    = inflight_pc;
  assign resp_entry.pc4   = inflight_pc + XLEN'(PC_INC);
  assign resp_entry.instr = IF_inIDATA;

`ifdef IF_BYPASS_EN
  assign head_sel   = fifo_empty ? resp_entry : fifo_head;
  assign head_valid = !fifo_empty || resp_ok;
  assign fifo_push  = resp_ok && !(fifo_empty && IF_inREADY);
`else
  assign head_sel   = fifo_head;
  assign head_valid = !fifo_empty;
  assign fifo_push  = resp_ok;
`endif
  assign fifo_pop = !redirect && !fifo_empty && IF_inREADY;

  if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (redirect),
    .din   (resp_entry),
    .count (fifo_count),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pc_q           <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      if (redirect) begin
        pc_q  <= target;
        epoch <= ~epoch;
      end else if (issue) begin
        pc_q <= pc_q + XLEN'(PC_INC);
      end
      inflight <= issue;
      if (issue) begin
        inflight_pc    <= pc_q;
        inflight_epoch <= epoch;
      end
    end
  end

  assign IF_outIREQ      = issue;
  assign IF_outIADADD    = pc_q;
  assign IF_outFLASHIF   = RESET && redirect;
  assign IF_outVALID     = RESET && !redirect && head_valid;
  assign IF_outINSTR     = IF_outVALID ? head_sel.instr : '0;
  assign IF_outPC        = IF_outVALID ? head_sel.pc    : '0;
  assign IF_outgoifidpc4 = IF_outVALID ? head_sel.pc4   : '0;

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised next-generation instruction-fetch stage.
- Owns the PC, next-PC redirect selection and flush generation.
- Issues fetches to a fixed 1-cycle-latency instruction memory and buffers returned instructions in a DEPTH-entry queue, so memory latency is decoupled from ID stalls.
- Sits between instruction memory and the IF/ID pipeline register; replaces the single-cycle PC/adder/mux IF stage.

Parameters:
XLEN, 32, width of PC, targets and instruction word
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 4, instruction queue entries (power of 2, >=2)
PC_INC, 4, sequential PC increment

Ports:
CLOCK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
IF_inREADY  in  1  ID accepts head entry this cycle
IF_inPCSRC  in  1  branch taken redirect
IF_inBRANCHGO  in  XLEN  branch target
IF_inJUMP  in  1  J/JAL redirect
IF_inJJAL  in  XLEN  J/JAL target
IF_inRJUMP  in  1  JR/JALR redirect
IF_inJRJALR  in  XLEN  JR/JALR target
IF_inIDATA  in  XLEN  imem read data, valid 1 cycle after IF_outIREQ
IF_outIREQ  out  1  fetch request this cycle
IF_outIADADD  out  XLEN  fetch address (= PC)
IF_outVALID  out  1  head entry valid to ID
IF_outINSTR  out  XLEN  head instruction
IF_outPC  out  XLEN  head instruction address
IF_outgoifidpc4  out  XLEN  head PC + PC_INC
IF_outFLASHIF  out  1  flush IF/ID this cycle

Behaviour:
- Reset (RESET=0, async): PC=RESET_PC, queue empty (count=0), in-flight flag=0, epoch=0. All outputs 0 except IF_outIADADD=RESET_PC.
- Redirect = IF_inRJUMP | IF_inJUMP | IF_inPCSRC.
  - Priority: RJUMP > JUMP > PCSRC.
  - Next PC = the selected target.
  - IF_outFLASHIF = redirect (combinational, same cycle).
- In a redirect cycle:
  - IF_outIREQ=0 and IF_outVALID=0; no pop.
  - Queue is cleared at the clock edge.
  - The epoch toggles, so an in-flight response returning next cycle is discarded.
- Issue: IF_outIREQ = !redirect & (count + inflight < DEPTH).
  - The check is conservative: a pop in the same cycle is not credited.
  - On issue: PC <= PC + PC_INC (modulo 2^XLEN, wraps silently); in-flight register captures {PC, epoch}.
- Response: the cycle after issue, IF_inIDATA is pushed as {pc, pc+PC_INC, data}, unless the captured epoch differs from the current epoch or a redirect is active this cycle.
- Pop: IF_outVALID & IF_inREADY. Push and pop in the same cycle leave count unchanged.
- Occupancy: count never exceeds DEPTH by construction; an overflow push is an assertion failure.
- Head outputs:
  - IF_outINSTR/PC/pc4 present the head entry whenever IF_outVALID=1.
  - They hold their value while IF_inREADY=0.
  - They are don't-care when the queue is empty.
- Steady state with READY=1: one instruction per cycle, 2-cycle IREQ-to-VALID latency (1 with bypass).
- Reset mid-operation: state returns to reset values immediately; a pending imem response is ignored because inflight=0.

Optional Feature:
- Macro: IF_BYPASS_EN.
- Defined:
  - When the queue is empty and a valid response arrives, the response drives IF_outVALID/INSTR/PC/pc4 combinationally in the same cycle.
  - If IF_inREADY=1 it is consumed without a push; otherwise it is pushed.
  - IREQ-to-VALID latency is 1.
- Undefined: every response is pushed first; latency is 2.

Decomposition:
- Package if_pkg holds:
  - XLEN default, PC_INC, RESET_PC default.
  - Typedef fetch_entry_t {pc, pc4, instr}.
  - Redirect-select enum (NONE, BRANCH, JAL, JALR).
- One sub-module: if_fetch_fifo.
  - Parametrised DEPTH of fetch_entry_t.
  - Ports: push, pop, clear, count, head, full, empty.
  - Uses the same CLOCK/RESET convention.
- PC, issue, epoch and redirect logic stay in if_fetch_queue.

Test Plan:
- Reset then release, READY=1, imem returns addr>>2 -> IREQ at 0x0,0x4,0x8,...; VALID from cycle 2 with PC=0x0, INSTR=0, pc4=0x4, one per cycle.
- READY=0 for 10 cycles after start -> exactly DEPTH=4 requests issued, IREQ low thereafter. Raise READY -> entries 0x0..0xC delivered in order, no loss or duplicates.
- JUMP=1 with JJAL=0x100 while 3 entries queued and 1 in flight -> FLASHIF=1 that cycle, VALID=0 next cycle, next IREQ address 0x100, first VALID PC=0x100, stale response dropped.
- RJUMP, JUMP and PCSRC all asserted, targets 0x300/0x200/0x100 -> next fetch at 0x300.
- Set PC to 0xFFFF_FFFC by redirect -> next sequential fetch 0x0000_0000; delivered pc4 for that entry = 0x0.
- RESET low mid-stream with 2 entries queued -> VALID=0 and IADADD=RESET_PC immediately; after release, first delivered PC=RESET_PC.
